// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO controller for the icache and LSB clients.
// Round-robin grant, serialised transfers, UART back-pressure on IO stores.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'('h30000)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     io_buffer_full,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_WIDTH-1:0]    mem_a,
  output logic                     mem_wr,
  input  logic                     ic_req_en,
  input  logic [ADDR_WIDTH-1:0]    ic_req_addr,
  output logic                     ic_resp_en,
  output logic [32*LINE_WORDS-1:0] ic_resp_data,
  input  logic                     lsb_req_en,
  input  logic                     lsb_req_we,
  input  logic [ADDR_WIDTH-1:0]    lsb_req_addr,
  input  logic [1:0]               lsb_req_len,
  input  logic [31:0]              lsb_req_data,
  output logic                     lsb_resp_en,
  output logic [31:0]              lsb_resp_data
);

  localparam int IC_N = 4 * LINE_WORDS;
  localparam int CW = $clog2(IC_N + 1);
  localparam logic [ADDR_WIDTH-1:0] IO_ALT =
    IO_BASE + ADDR_WIDTH'(4);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  logic                    last_lsb;
  logic                    cur_lsb;
  logic [ADDR_WIDTH-1:0]   base;
  logic [CW-1:0]           cur_n;
  logic [CW-1:0]           cnt;
  logic [31:0]             wdata;
  logic [32*LINE_WORDS-1:0] ic_buf;
  logic [31:0]             lsb_buf;

  logic                    lsb_io;
  logic [CW-1:0]           lsb_n;
  logic                    ic_ok;
  logic                    lsb_ok;
  logic                    pick_lsb;
  logic [CW-1:0]           lane;
  logic [ADDR_WIDTH-1:0]   cur_a;
  logic                    addr_phase;

  assign lsb_io = (lsb_req_addr == IO_BASE) ||
                  (lsb_req_addr == IO_ALT);

  always_comb begin
    lsb_n = CW'(4);
    case (lsb_req_len)
      2'd0:    lsb_n = CW'(1);
      2'd1:    lsb_n = CW'(2);
      default: lsb_n = CW'(4);
    endcase
    if (lsb_req_we && lsb_io) lsb_n = CW'(1);
  end

  // A UART store held off by a full buffer must not stall the icache.
  assign ic_ok  = ic_req_en & rdy_in;
  assign lsb_ok = lsb_req_en & rdy_in &
                  ~(lsb_req_we & lsb_io & io_buffer_full);
  assign pick_lsb = lsb_ok & (~ic_ok | ~last_lsb);

  assign lane  = cnt - CW'(1);
  assign cur_a = base + ADDR_WIDTH'(cnt);
  assign addr_phase = ((state == READ) && (cnt != cur_n)) ||
                      (state == WRITE);

  assign mem_wr   = (state == WRITE);
  assign mem_a    = addr_phase ? cur_a : '0;
  assign mem_dout = (state == WRITE) ?
                    wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;

  assign ic_resp_en    = (state == DONE) & ~cur_lsb;
  assign lsb_resp_en   = (state == DONE) & cur_lsb;
  assign ic_resp_data  = ic_buf;
  assign lsb_resp_data = lsb_buf;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      last_lsb <= 1'b0;
      cur_lsb  <= 1'b0;
      base     <= '0;
      cur_n    <= '0;
      cnt      <= '0;
      wdata    <= '0;
      ic_buf   <= '0;
      lsb_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_ok || lsb_ok) begin
            cur_lsb  <= pick_lsb;
            last_lsb <= pick_lsb;
            cnt      <= '0;
            if (pick_lsb) begin
              base    <= lsb_req_addr;
              cur_n   <= lsb_n;
              wdata   <= lsb_req_data;
              lsb_buf <= '0;
              state   <= lsb_req_we ? WRITE : READ;
            end else begin
              base   <= ic_req_addr;
              cur_n  <= CW'(IC_N);
              ic_buf <= '0;
              state  <= READ;
            end
          end
        end
        READ: begin
          // mem_din lags the address by one cycle
          if (cnt != '0) begin
            if (cur_lsb)
              lsb_buf[{lane[1:0], 3'b000} +: 8] <= mem_din;
            else
              ic_buf[{lane, 3'b000} +: 8] <= mem_din;
          end
          if (cnt == cur_n) state <= DONE;
          else cnt <= cnt + CW'(1);
        end
        WRITE: begin
          if (cnt == cur_n - CW'(1)) state <= DONE;
          else cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
